// File: rtl/vecdot_pkg.sv
// Shared types and constants for the vector dot-product accumulator.
// sat16 clamps a wide signed sum into a Q8.8 result and flags the clamp.
package vecdot_pkg;

   localparam int LANES    = 16;
   localparam int DW       = 16;
   localparam int ACC_W    = 32;
   localparam int TREE_LAT = 4;
   localparam int Q_FRAC   = 8;
   localparam int TREE_W   = DW + 4;

   localparam logic signed [ACC_W-1:0] Q_MAX = 32'sd32767;
   localparam logic signed [ACC_W-1:0] Q_MIN = -32'sd32768;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_e;

   typedef struct packed {
      logic          ovf;
      logic [DW-1:0] val;
   } sat_t;

   function automatic sat_t sat16(input logic signed [ACC_W-1:0] x);
      sat_t r;
      if (x > Q_MAX) begin
         r.ovf = 1'b1;
         r.val = 16'h7FFF;
      end else if (x < Q_MIN) begin
         r.ovf = 1'b1;
         r.val = 16'h8000;
      end else begin
         r.ovf = 1'b0;
         r.val = x[DW-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/vecdot_accum_tree.sv
// Registered signed 16->8->4->2->1 reduction; each level grows one bit.
// valid/last tags ride a shift register matching the four-level latency.
import vecdot_pkg::*;

module vec_add_tree_16 (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [LANES*DW-1:0]      data,
   input  logic                     in_v,
   input  logic                     in_last,
   output logic signed [TREE_W-1:0] sum,
   output logic                     out_v,
   output logic                     out_last
);

   logic signed [DW-1:0] lane_s [LANES];
   logic signed [DW:0]   l1_r   [LANES/2];
   logic signed [DW+1:0] l2_r   [LANES/4];
   logic signed [DW+2:0] l3_r   [LANES/8];
   logic signed [DW+3:0] l4_r;
   logic [TREE_LAT-1:0]  v_r;
   logic [TREE_LAT-1:0]  last_r;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_s[g] = data[g*DW +: DW];
   end

   // Tag pipeline; only the tags need clearing so no stale sum is ever consumed
   always_ff @(posedge clk) begin
      if (rst) begin
         v_r    <= {TREE_LAT{1'b0}};
         last_r <= {TREE_LAT{1'b0}};
      end else begin
         v_r    <= {v_r[TREE_LAT-2:0], in_v};
         last_r <= {last_r[TREE_LAT-2:0], in_v & in_last};
      end
   end

   // Data pipeline: sign-extended pairwise adds, one level per stage
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES/2; i++) begin
         l1_r[i] <= {lane_s[2*i][DW-1], lane_s[2*i]} + {lane_s[2*i+1][DW-1], lane_s[2*i+1]};
      end
      for (int i = 0; i < LANES/4; i++) begin
         l2_r[i] <= {l1_r[2*i][DW], l1_r[2*i]} + {l1_r[2*i+1][DW], l1_r[2*i+1]};
      end
      for (int i = 0; i < LANES/8; i++) begin
         l3_r[i] <= {l2_r[2*i][DW+1], l2_r[2*i]} + {l2_r[2*i+1][DW+1], l2_r[2*i+1]};
      end
      l4_r <= {l3_r[0][DW+2], l3_r[0]} + {l3_r[1][DW+2], l3_r[1]};
   end

   assign sum      = l4_r;
   assign out_v    = v_r[TREE_LAT-1];
   assign out_last = last_r[TREE_LAT-1];

endmodule

// File: rtl/vecdot_accum.sv
// Captures 16-lane product beats, reduces them through the adder tree and
// accumulates a programmed number of beats into one saturated Q8.8 result.
import vecdot_pkg::*;

module vecdot_accum (
   input  logic                clk,
   input  logic                rst,
   input  logic                mult_res_v,
   input  logic [LANES*DW-1:0] mult_res,
   input  logic                start,
   input  logic [7:0]          vec_len,
   output logic                busy,
   output logic                dot_v,
   output logic [DW-1:0]       dot_res,
   output logic                dot_ovf,
   output logic                drop_err
);

   state_e                     state_r;
   logic [8:0]                 beats_left_r;
   logic [LANES*DW-1:0]        in_data_r;
   logic                       in_v_r;
   logic                       in_last_r;
   logic signed [ACC_W-1:0]    acc_r;
   logic signed [TREE_W-1:0]   tree_sum_s;
   logic                       tree_v_s;
   logic                       tree_last_s;
   logic signed [ACC_W-1:0]    tree_ext_s;
   logic signed [ACC_W-1:0]    final_s;
   logic                       beat_s;
   sat_t                       sat_s;

   assign beat_s     = mult_res_v && (state_r == ACCUM);
   assign tree_ext_s = {{(ACC_W-TREE_W){tree_sum_s[TREE_W-1]}}, tree_sum_s};
   assign final_s    = acc_r + tree_ext_s;
   assign sat_s      = sat16(final_s);

   vec_add_tree_16 u_tree (
      .clk      (clk),
      .rst      (rst),
      .data     (in_data_r),
      .in_v     (in_v_r),
      .in_last  (in_last_r),
      .sum      (tree_sum_s),
      .out_v    (tree_v_s),
      .out_last (tree_last_s)
   );

   // Data is captured on any valid beat; only beats seen in ACCUM are tagged valid
   always_ff @(posedge clk) begin
      if (rst) begin
         in_data_r <= {(LANES*DW){1'b0}};
         in_v_r    <= 1'b0;
         in_last_r <= 1'b0;
      end else begin
         if (mult_res_v) begin
            in_data_r <= mult_res;
         end
         in_v_r    <= beat_s;
         in_last_r <= beat_s && (beats_left_r == 9'd1);
      end
   end

   // Control FSM, accumulator and registered result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         beats_left_r <= 9'd0;
         acc_r        <= {ACC_W{1'b0}};
         busy         <= 1'b0;
         dot_v        <= 1'b0;
         dot_res      <= {DW{1'b0}};
         dot_ovf      <= 1'b0;
         drop_err     <= 1'b0;
      end else begin
         dot_v <= 1'b0;
         if (mult_res_v && (state_r != ACCUM)) begin
            drop_err <= 1'b1;
         end
         if (tree_v_s) begin
            acc_r <= final_s;
            if (tree_last_s) begin
               dot_res <= sat_s.val;
               dot_ovf <= sat_s.ovf;
               dot_v   <= 1'b1;
            end
         end
         case (state_r)
            IDLE: begin
               if (start) begin
                  beats_left_r <= (vec_len == 8'd0) ? 9'd256 : {1'b0, vec_len};
                  acc_r        <= {ACC_W{1'b0}};
                  state_r      <= ACCUM;
                  busy         <= 1'b1;
               end
            end
            ACCUM: begin
               if (mult_res_v) begin
                  beats_left_r <= beats_left_r - 9'd1;
                  if (beats_left_r == 9'd1) begin
                     state_r <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (tree_v_s && tree_last_s) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vecdot_accum.sv
// Directed bench for vecdot_accum: a beat-level reference model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_vecdot_accum;

   logic         clk;
   logic         rst;
   logic         mult_res_v;
   logic [255:0] mult_res;
   logic         start;
   logic [7:0]   vec_len;
   logic         busy;
   logic         dot_v;
   logic [15:0]  dot_res;
   logic         dot_ovf;
   logic         drop_err;

   int checks = 0;
   int errors = 0;

   vecdot_accum dut (
      .clk        (clk),
      .rst        (rst),
      .mult_res_v (mult_res_v),
      .mult_res   (mult_res),
      .start      (start),
      .vec_len    (vec_len),
      .busy       (busy),
      .dot_v      (dot_v),
      .dot_res    (dot_res),
      .dot_ovf    (dot_ovf),
      .drop_err   (drop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [255:0] fill(input logic [15:0] v);
      return {16{v}};
   endfunction

   function automatic logic [255:0] alt(input logic [15:0] a, input logic [15:0] b);
      logic [255:0] d;
      for (int i = 0; i < 16; i++) d[16*i +: 16] = (i % 2 == 0) ? a : b;
      return d;
   endfunction

   function automatic longint lane_sum(input logic [255:0] d);
      longint s = 0;
      for (int i = 0; i < 16; i++) s += longint'($signed(d[16*i +: 16]));
      return s;
   endfunction

   // Reference model: beats counted per vector, result due 5 edges after the last beat
   int          cyc = 0;
   int          remaining = 0;
   bit          pending = 0;
   int          due = 0;
   longint      sum = 0;
   logic [15:0] pend_res;
   logic        pend_ovf;
   logic        m_v = 0, m_busy = 0, m_drop = 0, m_ovf = 0;
   logic [15:0] m_res = 16'h0000;
   bit          ready = 0;
   int          dotv_count = 0;

   always @(posedge clk) begin
      bit idle;
      cyc++;
      if (rst) begin
         remaining = 0; pending = 0; m_v = 0; m_res = 16'h0000;
         m_ovf = 0; m_drop = 0; m_busy = 0;
      end else begin
         idle = (remaining == 0) && !pending;
         m_v  = 0;
         if (pending && cyc == due) begin
            m_v = 1; m_res = pend_res; m_ovf = pend_ovf; pending = 0;
         end
         if (mult_res_v) begin
            if (remaining > 0) begin
               sum += lane_sum(mult_res);
               remaining--;
               if (remaining == 0) begin
                  pending = 1;
                  due     = cyc + 5;
                  if (sum > 32767) begin pend_res = 16'h7FFF; pend_ovf = 1; end
                  else if (sum < -32768) begin pend_res = 16'h8000; pend_ovf = 1; end
                  else begin pend_res = 16'(sum); pend_ovf = 0; end
               end
            end else begin
               m_drop = 1;
            end
         end
         if (start && idle) begin
            remaining = (vec_len == 8'd0) ? 256 : int'(vec_len);
            sum       = 0;
         end
         m_busy = (remaining > 0) || pending;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (ready) begin
         chk("dot_v", {31'd0, dot_v}, {31'd0, m_v});
         chk("busy", {31'd0, busy}, {31'd0, m_busy});
         chk("drop_err", {31'd0, drop_err}, {31'd0, m_drop});
         chk("dot_res", {16'd0, dot_res}, {16'd0, m_res});
         chk("dot_ovf", {31'd0, dot_ovf}, {31'd0, m_ovf});
         if (dot_v) dotv_count++;
      end
   end

   int last_beat_cyc = 0;
   int dotv_cyc = 0;

   task automatic beat(input logic [255:0] d);
      mult_res   = d;
      mult_res_v = 1'b1;
      @(negedge clk);
      mult_res_v = 1'b0;
      last_beat_cyc = cyc;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_vec(input logic [7:0] len);
      start   = 1'b1;
      vec_len = len;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_dot(input string name, input logic [15:0] exp_res, input logic exp_ovf);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (dot_v) begin
            seen     = 1;
            dotv_cyc = cyc;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: no dot_v within 40 cycles", name);
      end else begin
         chk({name, "_res"}, {16'd0, dot_res}, {16'd0, exp_res});
         chk({name, "_ovf"}, {31'd0, dot_ovf}, {31'd0, exp_ovf});
      end
   endtask

   initial begin
      int n0;
      rst = 1'b1; mult_res_v = 1'b0; mult_res = 256'd0; start = 1'b0; vec_len = 8'd0;
      idle_cycles(3);
      rst = 1'b0;
      ready = 1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_res", {16'd0, dot_res}, 32'd0);

      // vec_len 1, lanes 1.0, latency 5
      start_vec(8'd1);
      chk("t1_busy_after_start", {31'd0, busy}, 32'd1);
      beat(fill(16'h0100));
      wait_dot("t1", 16'h1000, 1'b0);
      chk("t1_latency", dotv_cyc - last_beat_cyc, 32'd5);
      idle_cycles(2);

      // vec_len 4 back-to-back
      start_vec(8'd4);
      for (int i = 0; i < 4; i++) beat(fill(16'h0080));
      wait_dot("t2", 16'h2000, 1'b0);
      chk("t2_busy_low_at_dot", {31'd0, busy}, 32'd0);
      idle_cycles(2);

      // vec_len 3 with gaps, alternating lanes cancel
      n0 = dotv_count;
      start_vec(8'd3);
      for (int i = 0; i < 3; i++) begin
         beat(alt(16'h0200, 16'hFE00));
         if (i < 2) idle_cycles(2);
      end
      wait_dot("t3", 16'h0000, 1'b0);
      idle_cycles(10);
      chk("t3_one_dot", dotv_count - n0, 32'd1);

      // saturation high and low
      start_vec(8'd16);
      for (int i = 0; i < 16; i++) beat(fill(16'h7FFF));
      wait_dot("t4", 16'h7FFF, 1'b1);
      idle_cycles(2);
      start_vec(8'd16);
      for (int i = 0; i < 16; i++) beat(fill(16'h8000));
      wait_dot("t5", 16'h8000, 1'b1);
      idle_cycles(2);

      // beat in IDLE is dropped, sticky error, no result
      n0 = dotv_count;
      beat(fill(16'h0100));
      idle_cycles(10);
      chk("t6_drop_err", {31'd0, drop_err}, 32'd1);
      chk("t6_no_dot", dotv_count - n0, 32'd0);

      // start during ACCUM ignored
      start_vec(8'd2);
      beat(fill(16'h0100));
      start_vec(8'd5);
      beat(fill(16'h0200));
      wait_dot("t7", 16'h3000, 1'b0);

      // start during the dot_v cycle is accepted
      start_vec(8'd1);
      beat(fill(16'h0040));
      wait_dot("t8", 16'h0400, 1'b0);
      idle_cycles(2);

      // start and beat together in IDLE: beat dropped, start taken
      start = 1'b1; vec_len = 8'd1; mult_res = fill(16'h7000); mult_res_v = 1'b1;
      @(negedge clk);
      start = 1'b0; mult_res_v = 1'b0;
      beat(fill(16'h0010));
      wait_dot("t9", 16'h0100, 1'b0);
      idle_cycles(2);

      // vec_len 0 means 256 beats
      start_vec(8'd0);
      for (int i = 0; i < 256; i++) beat(fill(16'h0001));
      wait_dot("t10", 16'h1000, 1'b0);
      idle_cycles(2);

      // reset abort after 2 of 4 beats
      n0 = dotv_count;
      start_vec(8'd4);
      beat(fill(16'h0100));
      beat(fill(16'h0100));
      rst = 1'b1;
      @(negedge clk);
      chk("t11_busy", {31'd0, busy}, 32'd0);
      chk("t11_dot_v", {31'd0, dot_v}, 32'd0);
      chk("t11_dot_res", {16'd0, dot_res}, 32'd0);
      chk("t11_dot_ovf", {31'd0, dot_ovf}, 32'd0);
      chk("t11_drop_err", {31'd0, drop_err}, 32'd0);
      rst = 1'b0;
      idle_cycles(12);
      chk("t11_no_dot", dotv_count - n0, 32'd0);
      start_vec(8'd1);
      beat(fill(16'h0100));
      wait_dot("t12", 16'h1000, 1'b0);
      idle_cycles(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
